// File: rtl/snake_body_engine.sv
// snake_body_engine
//   Snake state engine for the VGA snake game. Keeps up to MAX_LEN body
//   segments on a GRID_W x GRID_H cell grid and steps the snake once every
//   TICK_DIV clocks while play is enabled. Turn requests are buffered, with
//   reversals rejected. Growth requests are queued. Wall and self collisions
//   are checked against the next head position. The engine also classifies
//   the current VGA pixel for the renderer.
//
// Ports
//   clk                    system clock
//   reset                  asynchronous active-low reset
//   left/right/up/down_press  debounced key levels
//   run                    1 = play, stepping enabled
//   add_cube               growth request level (rising edge queues one)
//   die_flash              1 = snake pixels visible
//   x_pos, y_pos           current VGA pixel
//   snake                  pixel class 00 NONE / 01 HEAD / 10 BODY / 11 WALL
//   cube_num               current length
//   head_x, head_y         head cell
//   step                   one-clock pulse per completed move
//   hit_wall, hit_body     sticky collision flags
module snake_body_engine #(
   parameter int MAX_LEN    = 32,
   parameter int INIT_LEN   = 3,
   parameter int GRID_W     = 40,
   parameter int GRID_H     = 30,
   parameter int CELL_SHIFT = 4,
   parameter int TICK_DIV   = 12500000,
   parameter int WRAP       = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left_press,
   input  logic       right_press,
   input  logic       up_press,
   input  logic       down_press,
   input  logic       run,
   input  logic       add_cube,
   input  logic       die_flash,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   output logic [1:0] snake,
   output logic [6:0] cube_num,
   output logic [5:0] head_x,
   output logic [5:0] head_y,
   output logic       step,
   output logic       hit_wall,
   output logic       hit_body
);

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_e;

   localparam logic        WALLS     = (WRAP == 0);
   localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

   function automatic dir_e opposite(input dir_e d);
      case (d)
         DIR_RIGHT: opposite = DIR_LEFT;
         DIR_LEFT:  opposite = DIR_RIGHT;
         DIR_UP:    opposite = DIR_DOWN;
         DIR_DOWN:  opposite = DIR_UP;
         default:   opposite = DIR_RIGHT;
      endcase
   endfunction

   logic [5:0]  seg_x_q [MAX_LEN];
   logic [5:0]  seg_y_q [MAX_LEN];
   logic [5:0]  seg_x_d [MAX_LEN];
   logic [5:0]  seg_y_d [MAX_LEN];
   logic [6:0]  len_q, len_d;
   dir_e        committed_q, committed_d, pending_q, pending_d;
   logic [31:0] tick_q, tick_d;
   logic [3:0]  grow_q, grow_d;
   logic        add_prev_q, add_prev_d;
   logic        step_q, step_d;
   logic        hit_wall_q, hit_wall_d;
   logic        hit_body_q, hit_body_d;

   logic        dead_s, active_s, tick_end_s;
   logic        key_valid_s, key_accept_s;
   dir_e        key_dir_s;
   logic [5:0]  nx_s, ny_s;
   logic        wall_s, body_s, grow_apply_s, move_s, rise_s, consume_s;
   logic [9:0]  cell_x_s, cell_y_s;
   logic        on_grid_s, border_s, head_pix_s, body_pix_s;

   assign dead_s       = hit_wall_q | hit_body_q;
   assign active_s     = run & ~dead_s;
   assign tick_end_s   = active_s & (tick_q == TICK_LAST);
   // At full length a queued request is consumed but adds nothing.
   assign grow_apply_s = (grow_q != 4'd0) && (len_q < 7'(MAX_LEN));
   assign move_s       = tick_end_s & ~wall_s & ~body_s;
   assign rise_s       = add_cube & ~add_prev_q;
   assign consume_s    = move_s & (grow_q != 4'd0);

   // Key priority decode and reversal filter against the last committed move
   always_comb begin
      key_valid_s = 1'b1;
      key_dir_s   = DIR_RIGHT;
      if (left_press)       key_dir_s = DIR_LEFT;
      else if (right_press) key_dir_s = DIR_RIGHT;
      else if (up_press)    key_dir_s = DIR_UP;
      else if (down_press)  key_dir_s = DIR_DOWN;
      else                  key_valid_s = 1'b0;
      key_accept_s = key_valid_s && (key_dir_s != opposite(committed_q));
   end

   // Next head cell along the pending direction, with wall or torus handling
   always_comb begin
      nx_s   = seg_x_q[0];
      ny_s   = seg_y_q[0];
      wall_s = 1'b0;
      case (pending_q)
         DIR_RIGHT: begin
            wall_s = WALLS && (seg_x_q[0] >= 6'(GRID_W - 2));
            if (seg_x_q[0] >= 6'(GRID_W - 1)) nx_s = 6'd0;
            else                              nx_s = seg_x_q[0] + 6'd1;
         end
         DIR_LEFT: begin
            wall_s = WALLS && (seg_x_q[0] <= 6'd1);
            if (seg_x_q[0] == 6'd0) nx_s = 6'(GRID_W - 1);
            else                    nx_s = seg_x_q[0] - 6'd1;
         end
         DIR_UP: begin
            wall_s = WALLS && (seg_y_q[0] <= 6'd1);
            if (seg_y_q[0] == 6'd0) ny_s = 6'(GRID_H - 1);
            else                    ny_s = seg_y_q[0] - 6'd1;
         end
         DIR_DOWN: begin
            wall_s = WALLS && (seg_y_q[0] >= 6'(GRID_H - 2));
            if (seg_y_q[0] >= 6'(GRID_H - 1)) ny_s = 6'd0;
            else                              ny_s = seg_y_q[0] + 6'd1;
         end
         default: begin
            nx_s = seg_x_q[0];
         end
      endcase
   end

   // Self collision: the tail is ignored when it is about to vacate its cell
   always_comb begin
      body_s = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         body_s = body_s | ((7'(i) < len_q) &&
                            ((7'(i) != (len_q - 7'd1)) || grow_apply_s) &&
                            (seg_x_q[i] == nx_s) && (seg_y_q[i] == ny_s));
      end
   end

   // Next state: tick counter, move/shift, flags, direction and growth queue
   always_comb begin
      seg_x_d     = seg_x_q;
      seg_y_d     = seg_y_q;
      len_d       = len_q;
      committed_d = committed_q;
      pending_d   = pending_q;
      tick_d      = tick_q;
      step_d      = 1'b0;
      hit_wall_d  = hit_wall_q;
      hit_body_d  = hit_body_q;
      add_prev_d  = add_cube;

      if (tick_end_s)    tick_d = 32'd0;
      else if (active_s) tick_d = tick_q + 32'd1;
      else               tick_d = tick_q;

      if (tick_end_s && wall_s)      hit_wall_d = 1'b1;
      else if (tick_end_s && body_s) hit_body_d = 1'b1;
      else if (move_s) begin
         seg_x_d[0] = nx_s;
         seg_y_d[0] = ny_s;
         // Shifting every slot also carries the old tail into the new slot on growth.
         for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
         end
         committed_d = pending_q;
         step_d      = 1'b1;
         if (grow_apply_s) len_d = len_q + 7'd1;
         else              len_d = len_q;
      end else begin
         step_d = 1'b0;
      end

      if (key_accept_s) pending_d = key_dir_s;
      else              pending_d = pending_q;

      if (rise_s && !consume_s && (grow_q != 4'd15)) grow_d = grow_q + 4'd1;
      else if (consume_s && !rise_s)                 grow_d = grow_q - 4'd1;
      else                                           grow_d = grow_q;
   end

   // Pixel classification for the renderer
   always_comb begin
      cell_x_s   = x_pos >> CELL_SHIFT;
      cell_y_s   = y_pos >> CELL_SHIFT;
      on_grid_s  = (x_pos < 10'd640) && (y_pos < 10'd480) &&
                   (cell_x_s < 10'(GRID_W)) && (cell_y_s < 10'(GRID_H));
      border_s   = (cell_x_s == 10'd0) || (cell_x_s == 10'(GRID_W - 1)) ||
                   (cell_y_s == 10'd0) || (cell_y_s == 10'(GRID_H - 1));
      head_pix_s = (cell_x_s == {4'd0, seg_x_q[0]}) && (cell_y_s == {4'd0, seg_y_q[0]});
      body_pix_s = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         body_pix_s = body_pix_s | ((7'(i) < len_q) &&
                                    (cell_x_s == {4'd0, seg_x_q[i]}) &&
                                    (cell_y_s == {4'd0, seg_y_q[i]}));
      end
      if (!on_grid_s)            snake = 2'b00;
      else if (WALLS && border_s) snake = 2'b11;
      else if (head_pix_s)       snake = die_flash ? 2'b01 : 2'b00;
      else if (body_pix_s)       snake = die_flash ? 2'b10 : 2'b00;
      else                       snake = 2'b00;
   end

   // State registers with asynchronous reset to the starting snake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            if (i < INIT_LEN) begin
               seg_x_q[i] <= 6'(10 - i);
               seg_y_q[i] <= 6'd5;
            end else begin
               seg_x_q[i] <= 6'd0;
               seg_y_q[i] <= 6'd0;
            end
         end
         len_q       <= 7'(INIT_LEN);
         committed_q <= DIR_RIGHT;
         pending_q   <= DIR_RIGHT;
         tick_q      <= 32'd0;
         grow_q      <= 4'd0;
         add_prev_q  <= 1'b0;
         step_q      <= 1'b0;
         hit_wall_q  <= 1'b0;
         hit_body_q  <= 1'b0;
      end else begin
         seg_x_q     <= seg_x_d;
         seg_y_q     <= seg_y_d;
         len_q       <= len_d;
         committed_q <= committed_d;
         pending_q   <= pending_d;
         tick_q      <= tick_d;
         grow_q      <= grow_d;
         add_prev_q  <= add_prev_d;
         step_q      <= step_d;
         hit_wall_q  <= hit_wall_d;
         hit_body_q  <= hit_body_d;
      end
   end

   assign cube_num = len_q;
   assign head_x   = seg_x_q[0];
   assign head_y   = seg_y_q[0];
   assign step     = step_q;
   assign hit_wall = hit_wall_q;
   assign hit_body = hit_body_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine. Three instances share all inputs:
//   inst0: walls, MAX_LEN=32;  inst1: torus, MAX_LEN=32;  inst2: walls, MAX_LEN=4.
// A queue-based snake model per instance predicts every observable output.
module tb_snake_body_engine;

   localparam int TICK = 4;
   localparam int GW   = 40;
   localparam int GH   = 30;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lp, rp, upk, dnk, run, add_cube, die_flash;
   logic [9:0] x_pos, y_pos;
   logic [1:0] snake_s [3];
   logic [21:0] dut_vec [3];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [6:0] cube_w;
      logic [5:0] hx_w, hy_w;
      logic       step_w, hw_w, hb_w;
      snake_body_engine #(
         .MAX_LEN(g == 2 ? 4 : 32), .INIT_LEN(3), .GRID_W(GW), .GRID_H(GH),
         .CELL_SHIFT(4), .TICK_DIV(TICK), .WRAP(g == 1 ? 1 : 0)
      ) u_dut (
         .clk(clk), .reset(rst_n),
         .left_press(lp), .right_press(rp), .up_press(upk), .down_press(dnk),
         .run(run), .add_cube(add_cube), .die_flash(die_flash),
         .x_pos(x_pos), .y_pos(y_pos),
         .snake(snake_s[g]), .cube_num(cube_w), .head_x(hx_w), .head_y(hy_w),
         .step(step_w), .hit_wall(hw_w), .hit_body(hb_w)
      );
      assign dut_vec[g] = {hx_w, hy_w, cube_w, step_w, hw_w, hb_w};
   end

   // ---------------- reference model ----------------
   int mx [3][$];
   int my [3][$];
   int cdx [3], cdy [3], pdx [3], pdy [3], mtick [3], mgrow [3];
   bit mwall [3], mbody [3], mstep [3];
   bit mprev;

   function automatic int maxlen_of(int k); return (k == 2) ? 4 : 32; endfunction
   function automatic bit wrap_of(int k);   return (k == 1); endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mx[k].delete(); my[k].delete();
         for (int i = 0; i < 3; i++) begin
            mx[k].push_back(10 - i);
            my[k].push_back(5);
         end
         cdx[k] = 1; cdy[k] = 0; pdx[k] = 1; pdy[k] = 0;
         mtick[k] = 0; mgrow[k] = 0;
         mwall[k] = 1'b0; mbody[k] = 1'b0; mstep[k] = 1'b0;
      end
      mprev = 1'b0;
   endtask

   task automatic model_update();
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 3; k++) begin
         int  ocdx, ocdy, nx, ny, kdx, kdy, last;
         bit  fire, consume, grow, wh, bh, kv, rise, alive;
         ocdx = cdx[k]; ocdy = cdy[k];
         consume = 1'b0;
         mstep[k] = 1'b0;
         alive = !(mwall[k] || mbody[k]);
         fire  = run && alive && (mtick[k] == TICK - 1);
         if (run && alive) mtick[k] = fire ? 0 : mtick[k] + 1;
         if (fire) begin
            nx = mx[k][0] + pdx[k];
            ny = my[k][0] + pdy[k];
            wh = 1'b0;
            if (wrap_of(k)) begin
               nx = (nx + GW) % GW;
               ny = (ny + GH) % GH;
            end else begin
               wh = (nx < 1) || (nx > GW - 2) || (ny < 1) || (ny > GH - 2);
            end
            grow = (mgrow[k] > 0) && (mx[k].size() < maxlen_of(k));
            bh = 1'b0;
            last = mx[k].size() - 1;
            for (int i = 1; i <= last; i++) begin
               if (!(i == last && !grow) && mx[k][i] == nx && my[k][i] == ny) bh = 1'b1;
            end
            if (wh) mwall[k] = 1'b1;
            else if (bh) mbody[k] = 1'b1;
            else begin
               mx[k].push_front(nx);
               my[k].push_front(ny);
               if (!grow) begin
                  void'(mx[k].pop_back());
                  void'(my[k].pop_back());
               end
               cdx[k] = pdx[k]; cdy[k] = pdy[k];
               mstep[k] = 1'b1;
               consume = (mgrow[k] > 0);
            end
         end
         kv = 1'b1; kdx = 0; kdy = 0;
         if (lp)       kdx = -1;
         else if (rp)  kdx = 1;
         else if (upk) kdy = -1;
         else if (dnk) kdy = 1;
         else          kv = 1'b0;
         if (kv && !(kdx == -ocdx && kdy == -ocdy)) begin
            pdx[k] = kdx; pdy[k] = kdy;
         end
         rise = add_cube && !mprev;
         if (rise && !consume && mgrow[k] < 15) mgrow[k]++;
         else if (consume && !rise) mgrow[k]--;
      end
      mprev = add_cube;
   endtask

   function automatic logic [21:0] model_vec(int k);
      return {6'(mx[k][0]), 6'(my[k][0]), 7'(mx[k].size()), mstep[k], mwall[k], mbody[k]};
   endfunction

   function automatic logic [1:0] classify(int k, int x, int y);
      int cx, cy;
      if (x >= 640 || y >= 480) return 2'b00;
      cx = x / 16; cy = y / 16;
      if (cx >= GW || cy >= GH) return 2'b00;
      if (!wrap_of(k) && (cx == 0 || cx == GW - 1 || cy == 0 || cy == GH - 1)) return 2'b11;
      if (mx[k][0] == cx && my[k][0] == cy) return die_flash ? 2'b01 : 2'b00;
      for (int i = 1; i < mx[k].size(); i++)
         if (mx[k][i] == cx && my[k][i] == cy) return die_flash ? 2'b10 : 2'b00;
      return 2'b00;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_inputs();
      lp = 1'b0; rp = 1'b0; upk = 1'b0; dnk = 1'b0;
      run = 1'b0; add_cube = 1'b0; die_flash = 1'b1;
      x_pos = 10'd0; y_pos = 10'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #2;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (dut_vec[k] !== {6'd10, 6'd5, 7'd3, 3'b000})
            $display("FAIL reset_state inst%0d got=%h exp=%h", k, dut_vec[k], {6'd10, 6'd5, 7'd3, 3'b000});
         else n_pass++;
      end
      x_pos = 10'd160; y_pos = 10'd80; #1;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (snake_s[k] !== 2'b01) $display("FAIL reset_head_pix inst%0d got=%b exp=01", k, snake_s[k]);
         else n_pass++;
      end
      x_pos = 10'd0; y_pos = 10'd0; #1;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (snake_s[k] !== ((k == 1) ? 2'b00 : 2'b11))
            $display("FAIL reset_corner_pix inst%0d got=%b exp=%b", k, snake_s[k], (k == 1) ? 2'b00 : 2'b11);
         else n_pass++;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_straight();
      run = 1'b1;
      for (int c = 0; c < 12; c++) begin
         cycle();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dut_vec[k] !== model_vec(k))
               $display("FAIL straight inst%0d t=%0t got=%h exp=%h", k, $time, dut_vec[k], model_vec(k));
            else n_pass++;
         end
      end
      n_checks++;
      if (dut_vec[0][21:16] !== 6'd13) $display("FAIL straight_head_x got=%0d exp=13", dut_vec[0][21:16]);
      else n_pass++;
      x_pos = 10'd208; y_pos = 10'd80; #1;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (snake_s[k] !== classify(k, 208, 80))
            $display("FAIL straight_pix inst%0d got=%b exp=%b", k, snake_s[k], classify(k, 208, 80));
         else n_pass++;
      end
   endtask

   task automatic test_turn();
      for (int c = 0; c < 4; c++) begin
         lp = (c == 0) || (c == 2);
         upk = (c == 1);
         cycle();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dut_vec[k] !== model_vec(k))
               $display("FAIL turn inst%0d t=%0t got=%h exp=%h", k, $time, dut_vec[k], model_vec(k));
            else n_pass++;
         end
      end
      lp = 1'b0; upk = 1'b0;
      n_checks++;
      if (dut_vec[0][21:10] !== {6'd13, 6'd4}) $display("FAIL turn_head got=%h exp=%h", dut_vec[0][21:10], {6'd13, 6'd4});
      else n_pass++;
   endtask

   task automatic test_random();
      int k, j;
      for (int c = 0; c < 600; c++) begin
         lp  = ($urandom_range(7) == 0);
         rp  = ($urandom_range(7) == 0);
         upk = ($urandom_range(7) == 0);
         dnk = ($urandom_range(7) == 0);
         run = ($urandom_range(9) != 0);
         add_cube = ($urandom_range(3) == 0);
         cycle();
         for (int m = 0; m < 3; m++) begin
            n_checks++;
            if (dut_vec[m] !== model_vec(m))
               $display("FAIL random_state inst%0d t=%0t got=%h exp=%h", m, $time, dut_vec[m], model_vec(m));
            else n_pass++;
         end
         die_flash = ($urandom_range(3) != 0);
         if ($urandom_range(1) == 0) begin
            k = $urandom_range(2);
            j = $urandom_range(mx[k].size() - 1);
            x_pos = 10'(mx[k][j] * 16 + $urandom_range(15));
            y_pos = 10'(my[k][j] * 16 + $urandom_range(15));
         end else begin
            x_pos = 10'($urandom_range(700));
            y_pos = 10'($urandom_range(520));
         end
         #1;
         for (int m = 0; m < 3; m++) begin
            n_checks++;
            if (snake_s[m] !== classify(m, int'(x_pos), int'(y_pos)))
               $display("FAIL random_pix inst%0d x=%0d y=%0d got=%b exp=%b", m, x_pos, y_pos,
                        snake_s[m], classify(m, int'(x_pos), int'(y_pos)));
            else n_pass++;
         end
      end
   endtask

   task automatic test_wall();
      do_reset();
      run = 1'b1;
      for (int c = 0; c < 133; c++) begin
         if (c == 6) run = 1'b0;
         if (c == 11) run = 1'b1;
         cycle();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dut_vec[k] !== model_vec(k))
               $display("FAIL wall inst%0d t=%0t got=%h exp=%h", k, $time, dut_vec[k], model_vec(k));
            else n_pass++;
         end
      end
      n_checks++;
      if ({dut_vec[0][21:16], dut_vec[0][2:1]} !== {6'd38, 2'b01})
         $display("FAIL wall_stop got=%h exp=%h", {dut_vec[0][21:16], dut_vec[0][2:1]}, {6'd38, 2'b01});
      else n_pass++;
      n_checks++;
      if ({dut_vec[1][21:16], dut_vec[1][1]} !== {6'd2, 1'b0})
         $display("FAIL wrap_head got=%h exp=%h", {dut_vec[1][21:16], dut_vec[1][1]}, {6'd2, 1'b0});
      else n_pass++;
   endtask

   task automatic test_growth();
      do_reset();
      for (int e = 0; e < 3; e++) begin
         add_cube = 1'b1; cycle();
         add_cube = 1'b0; cycle();
      end
      run = 1'b1;
      for (int c = 0; c < 16; c++) begin
         cycle();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dut_vec[k] !== model_vec(k))
               $display("FAIL growth inst%0d t=%0t got=%h exp=%h", k, $time, dut_vec[k], model_vec(k));
            else n_pass++;
         end
      end
      n_checks++;
      if ({dut_vec[0][9:3], dut_vec[2][9:3]} !== {7'd6, 7'd4})
         $display("FAIL growth_len got=%h exp=%h", {dut_vec[0][9:3], dut_vec[2][9:3]}, {7'd6, 7'd4});
      else n_pass++;
   endtask

   task automatic test_tail_chase(input bit with_growth);
      do_reset();
      add_cube = 1'b1; cycle();
      add_cube = 1'b0; cycle();
      run = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         upk = (c == 5);
         lp  = (c == 9);
         dnk = (c == 13);
         add_cube = with_growth && (c == 13);
         cycle();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dut_vec[k] !== model_vec(k))
               $display("FAIL tail_chase%0d inst%0d t=%0t got=%h exp=%h", with_growth, k, $time, dut_vec[k], model_vec(k));
            else n_pass++;
         end
      end
      upk = 1'b0; lp = 1'b0; dnk = 1'b0; add_cube = 1'b0;
      n_checks++;
      if ({dut_vec[0][0], dut_vec[1][0], dut_vec[2][0]} !== (with_growth ? 3'b110 : 3'b000))
         $display("FAIL tail_chase_hit%0d got=%b exp=%b", with_growth,
                  {dut_vec[0][0], dut_vec[1][0], dut_vec[2][0]}, with_growth ? 3'b110 : 3'b000);
      else n_pass++;
      n_checks++;
      if (dut_vec[0][21:10] !== (with_growth ? {6'd10, 6'd4} : {6'd10, 6'd5}))
         $display("FAIL tail_chase_head%0d got=%h exp=%h", with_growth, dut_vec[0][21:10],
                  with_growth ? {6'd10, 6'd4} : {6'd10, 6'd5});
      else n_pass++;
   endtask

   task automatic test_async_reset();
      n_checks++;
      if (dut_vec[0][0] !== 1'b1) $display("FAIL pre_reset_hit_body got=%b exp=1", dut_vec[0][0]);
      else n_pass++;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (dut_vec[k] !== {6'd10, 6'd5, 7'd3, 3'b000})
            $display("FAIL async_reset inst%0d got=%h exp=%h", k, dut_vec[k], {6'd10, 6'd5, 7'd3, 3'b000});
         else n_pass++;
      end
      model_reset();
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      test_reset();
      test_straight();
      test_turn();
      test_random();
      test_wall();
      test_growth();
      test_tail_chase(1'b0);
      test_tail_chase(1'b1);
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
